bsg_link_isdr_train_ctrl: RTL and testbench
===========================================

Name: bsg_link_isdr_train_ctrl

Overview:
Bring-up controller for the input SDR link. It sits in the PHY capture clock domain, directly after the per-bit capture flops, and checks the training pattern the remote transmitter drives. It declares lock only after a run of consecutive clean training words, and gates captured valid/data to the downstream link logic until lock. It reports a failure on timeout and supports retraining on request.

Parameters:
width_p, 16, captured data width; must be even and >= 2
lock_cnt_p, 16, consecutive good training words required for lock; >= 2
timeout_p, 1024, cycles allowed in SEARCH+CHECK before FAIL; > lock_cnt_p

Ports:
clk_i  input  1  PHY capture clock (buffered input-link clock)
reset_n_i  input  1  synchronous reset, active-low
phy_v_i  input  1  captured valid bit from the capture flops
phy_data_i  input  width_p  captured data from the capture flops
train_en_i  input  1  level; high = train/operate, low = return to IDLE
retrain_i  input  1  pulse; in LOCKED restarts training
v_o  output  1  gated valid to downstream
data_o  output  width_p  registered captured data
locked_o  output  1  high in LOCKED
train_fail_o  output  1  high in FAIL
lock_count_o  output  8  number of entries into LOCKED since reset, saturating at 255

Behaviour:
- Patterns:
  - P0 = {width_p/2{2'b10}}; P1 = ~P0.
  - A cycle is a "training word" if phy_v_i==0 and phy_data_i is P0 or P1.
- States: IDLE, SEARCH, CHECK, LOCKED, FAIL.
- Reset (reset_n_i==0 at a clk_i edge), all registers cleared:
  - state=IDLE, v_o=0, data_o=0, locked_o=0, train_fail_o=0, lock_count_o=0.
  - Internal counters and the prev register also cleared.
  - Reset asserted mid-operation behaves identically: no output is held over.
- Global rule: train_en_i==0 in any non-IDLE state -> IDLE next cycle. This rule has priority over all other transitions.
- IDLE: train_en_i==1 -> SEARCH; clear timer and match_cnt.
- SEARCH:
  - timer increments every cycle.
  - Training word -> CHECK, match_cnt=1, prev=phy_data_i.
- CHECK:
  - timer increments every cycle.
  - Good cycle: training word with phy_data_i == ~prev. Then prev=phy_data_i and match_cnt+1.
  - When the incremented match_cnt equals lock_cnt_p -> LOCKED, and lock_count_o increments (saturating).
  - Bad cycle: any other input -> SEARCH, match_cnt=0; timer is not cleared. A repeated word (e.g. P0,P0) counts as bad.
- Timeout: in SEARCH or CHECK, if timer == timeout_p-1 at the edge -> FAIL.
  - If lock and timeout occur on the same edge, LOCKED wins.
- LOCKED:
  - retrain_i==1 -> SEARCH; timer and match_cnt cleared; locked_o drops next cycle.
  - retrain_i is ignored in all other states.
- FAIL: sticky; left only via train_en_i==0 (-> IDLE) or reset.
- Datapath:
  - data_o <= phy_data_i every cycle, independent of state (after reset release).
  - v_o <= phy_v_i & (next state == LOCKED). Latency is 1 cycle.
  - v_o is never high in any cycle where locked_o is low.
- Registered outputs: locked_o and train_fail_o are decoded from the registered state. They change on the edge that enters or leaves the state.
- Counter widths:
  - match_cnt: $clog2(lock_cnt_p+1) bits.
  - timer: $clog2(timeout_p) bits.
  - Neither counter wraps: match_cnt stops at lock_cnt_p; timer stops at timeout_p-1.
- phy_v_i==1 during SEARCH or CHECK is a bad word; it is not forwarded.

Test Plan:
1. Clean lock, width_p=16, lock_cnt_p=16: reset, train_en_i=1, drive 0xAAAA/0x5555 alternating from cycle 3. Expect locked_o rising exactly 16 training cycles after the first word, lock_count_o=1, v_o=0 throughout training.
2. Broken run: alternate 10 words, inject 0xAAAB, then resume alternating. Expect return to SEARCH, match_cnt reset, and lock only after 16 new consecutive good words. Repeat with a duplicated 0xAAAA.
3. Timeout, timeout_p=64: drive 0x1234 constantly. Expect train_fail_o=1 on the 64th cycle after entering SEARCH, staying high. Drop train_en_i: expect IDLE and train_fail_o=0 next cycle.
4. Post-lock traffic: after lock, drive phy_v_i=1 with data 0xBEEF. Expect v_o=1 and data_o=0xBEEF one cycle later. Pulse retrain_i: expect locked_o=0 and v_o=0 next cycle, then relock and lock_count_o=2.
5. Reset mid-CHECK and mid-LOCKED: assert reset_n_i=0 for one cycle. Expect all outputs 0 and lock_count_o=0 next cycle; training restarts from IDLE.
6. Lock/timeout tie: timeout_p=20, lock_cnt_p=16, first training word at SEARCH cycle 4. Expect LOCKED and train_fail_o never asserted.

Source files
------------

// File: rtl/bsg_link_isdr_train_ctrl.sv
// bsg_link_isdr_train_ctrl: checks the alternating training pattern on the captured SDR link,
// locks after a clean run and gates valid/data downstream until lock.
module bsg_link_isdr_train_ctrl #(
    parameter int width_p    = 16,
    parameter int lock_cnt_p = 16,
    parameter int timeout_p  = 1024
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               phy_v_i,
    input  logic [width_p-1:0] phy_data_i,
    input  logic               train_en_i,
    input  logic               retrain_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               locked_o,
    output logic               train_fail_o,
    output logic [7:0]         lock_count_o
);
    localparam int mw = $clog2(lock_cnt_p + 1);
    localparam int tw = $clog2(timeout_p);
    localparam logic [width_p-1:0] p0 = {(width_p / 2){2'b10}};
    localparam logic [mw-1:0] match_lock = mw'(lock_cnt_p);
    localparam logic [tw-1:0] timer_max = tw'(timeout_p - 1);

    typedef enum logic [2:0] {IDLE, SEARCH, CHECK, LOCKED, FAIL} state_t;

    state_t               state, state_n;
    logic [mw-1:0]        match_cnt, match_n;
    logic [tw-1:0]        timer, timer_n;
    logic [width_p-1:0]   prev, prev_n;
    logic [7:0]           lock_count_n;
    logic                 train_word, good, timed_out;

    assign train_word = !phy_v_i && (phy_data_i == p0 || phy_data_i == ~p0);
    assign good       = train_word && phy_data_i == ~prev;
    assign timed_out  = timer == timer_max;
    assign locked_o     = state == LOCKED;
    assign train_fail_o = state == FAIL;

    always_comb begin
        state_n = state;
        match_n = match_cnt;
        timer_n = timer;
        prev_n  = prev;
        case (state)
            IDLE: if (train_en_i) begin
                state_n = SEARCH;
                timer_n = '0;
                match_n = '0;
            end
            SEARCH: begin
                timer_n = timed_out ? timer : timer + 1'b1;
                if (train_word) begin
                    state_n = CHECK;
                    match_n = mw'(1);
                    prev_n  = phy_data_i;
                end
                if (timed_out) state_n = FAIL;
            end
            CHECK: begin
                timer_n = timed_out ? timer : timer + 1'b1;
                if (good) begin
                    prev_n  = phy_data_i;
                    match_n = match_cnt + 1'b1;
                end else begin
                    state_n = SEARCH;
                    match_n = '0;
                end
                // a lock completing on the timeout edge takes precedence
                if (good && match_n == match_lock) state_n = LOCKED;
                else if (timed_out) state_n = FAIL;
            end
            LOCKED: if (retrain_i) begin
                state_n = SEARCH;
                timer_n = '0;
                match_n = '0;
            end
            default: ;
        endcase
        if (!train_en_i) state_n = IDLE;
    end

    assign lock_count_n = (state_n == LOCKED && state != LOCKED && lock_count_o != 8'hff)
                        ? lock_count_o + 1'b1 : lock_count_o;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            match_cnt    <= '0;
            timer        <= '0;
            prev         <= '0;
            lock_count_o <= '0;
            v_o          <= 1'b0;
            data_o       <= '0;
        end else begin
            state        <= state_n;
            match_cnt    <= match_n;
            timer        <= timer_n;
            prev         <= prev_n;
            lock_count_o <= lock_count_n;
            v_o          <= phy_v_i && state_n == LOCKED;
            data_o       <= phy_data_i;
        end
    end
endmodule

// File: tb/tb_bsg_link_isdr_train_ctrl.sv
// tb_bsg_link_isdr_train_ctrl: directed and random training traffic checked cycle by cycle
// against a behavioural model through an expected-output queue.
module tb_bsg_link_isdr_train_ctrl;
    localparam int W = 16;
    localparam int L = 16;
    localparam int T = 64;
    localparam logic [W-1:0] P0 = 16'hAAAA;
    localparam logic [W-1:0] P1 = 16'h5555;

    logic clk = 0;
    logic reset_n_i = 0, phy_v_i = 0, train_en_i = 0, retrain_i = 0;
    logic [W-1:0] phy_data_i = '0;
    logic v_o, locked_o, train_fail_o;
    logic [W-1:0] data_o;
    logic [7:0] lock_count_o;

    bsg_link_isdr_train_ctrl #(.width_p(W), .lock_cnt_p(L), .timeout_p(T)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .phy_v_i(phy_v_i), .phy_data_i(phy_data_i),
        .train_en_i(train_en_i), .retrain_i(retrain_i), .v_o(v_o), .data_o(data_o),
        .locked_o(locked_o), .train_fail_o(train_fail_o), .lock_count_o(lock_count_o)
    );

    always #5 clk = ~clk;

    logic [26:0] expq[$];
    int n_cmp = 0, n_err = 0, cyc_no = 0;

    // model: session active, locked/failed flags, current clean-run length, cycles spent training
    logic m_act = 0, m_lock = 0, m_fail = 0;
    int m_run = 0, m_el = 0, m_cnt = 0;
    logic [W-1:0] m_last = '0, last_w = '0;
    logic alt = 0;

    task automatic drive(input logic rn, input logic en, input logic rt, input logic v, input logic [W-1:0] d);
        logic tw;
        @(negedge clk);
        reset_n_i = rn; train_en_i = en; retrain_i = rt; phy_v_i = v; phy_data_i = d;
        last_w = d;
        if (!rn) begin
            m_act = 0; m_lock = 0; m_fail = 0; m_run = 0; m_el = 0; m_cnt = 0; m_last = '0;
            expq.push_back('0);
        end else begin
            if (!en) begin
                m_act = 0; m_lock = 0; m_fail = 0;
            end else if (!m_act) begin
                m_act = 1; m_el = 0; m_run = 0;
            end else if (m_lock) begin
                if (rt) begin m_lock = 0; m_el = 0; m_run = 0; end
            end else if (!m_fail) begin
                tw = !v && (d == P0 || d == P1);
                if (m_run == 0) m_run = tw ? 1 : 0;
                else m_run = (tw && d == ~m_last) ? m_run + 1 : 0;
                m_last = d;
                if (m_run == L) begin
                    m_lock = 1; m_run = 0;
                    if (m_cnt < 255) m_cnt++;
                end else if (m_el == T - 1) m_fail = 1;
                else m_el++;
            end
            expq.push_back({v & m_lock, m_lock, m_fail, 8'(m_cnt), d});
        end
    endtask

    task automatic train(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 1, 0, 0, alt ? P1 : P0);
            alt = ~alt;
        end
    endtask

    task automatic hold(input int n, input logic en, input logic [W-1:0] d);
        for (int i = 0; i < n; i++) drive(1, en, 0, 0, d);
    endtask

    always @(posedge clk) begin : monitor
        logic [26:0] e, a;
        #1;
        cyc_no++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {v_o, locked_o, train_fail_o, lock_count_o, data_o};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs cyc %0d: got v=%b lk=%b fl=%b cnt=%0d d=%h, want v=%b lk=%b fl=%b cnt=%0d d=%h",
                         cyc_no, a[26], a[25], a[24], a[23:16], a[15:0], e[26], e[25], e[24], e[23:16], e[15:0]);
            end
            n_cmp++;
            if (v_o === 1'b1 && locked_o !== 1'b1) begin
                n_err++;
                $display("FAIL v_gate cyc %0d: got v=%b locked=%b, want no valid while unlocked", cyc_no, v_o, locked_o);
            end
        end
    end

    initial begin
        int r;
        logic [W-1:0] d;
        hold(2, 0, '0);
        drive(0, 0, 0, 0, '0);
        drive(0, 0, 0, 0, '0);
        // clean lock
        hold(2, 1, 16'h0000);
        train(20);
        // post-lock traffic and retrain
        drive(1, 1, 0, 1, 16'hBEEF);
        drive(1, 1, 0, 1, 16'h1234);
        drive(1, 1, 1, 1, 16'hBEEF);
        train(20);
        // broken run: corrupted word, then duplicated word
        hold(1, 0, '0);
        train(10);
        drive(1, 1, 0, 0, 16'hAAAB);
        train(20);
        hold(1, 0, '0);
        train(10);
        drive(1, 1, 0, 0, last_w);
        train(20);
        // timeout then release
        hold(1, 0, '0);
        hold(70, 1, 16'h1234);
        hold(2, 0, 16'h1234);
        // reset in CHECK and in LOCKED
        train(8);
        drive(0, 1, 0, 0, P0);
        train(20);
        drive(0, 1, 0, 1, P1);
        train(20);
        // lock completing on the timeout edge
        hold(1, 0, '0);
        hold(49, 1, 16'h1234);
        train(16);
        hold(3, 1, 16'h0F0F);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) drive(0, 1, 0, 0, '0);
            else if (r < 13) drive(1, 0, 0, 0, 16'($urandom));
            else begin
                r = $urandom_range(0, 99);
                if (r < 4) d = 16'($urandom);
                else if (r < 6) d = last_w;
                else begin d = alt ? P1 : P0; alt = ~alt; end
                drive(1, 1, $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0, d);
            end
        end
        hold(2, 1, '0);
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        #3;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
